unsigned_divider: RTL and testbench

Sequential 16-by-8 unsigned restoring divider: accepts a 16-bit dividend and an 8-bit divisor and produces an 8-bit quotient and an 8-bit remainder. It is the inverse datapath of the team's 8x8 unsigned multiplier. It sits on the same arithmetic path, so a product from the multiplier can be divided back by either operand. It runs one quotient bit per clock under a start/done handshake and flags divide-by-zero and quotient overflow.

---
 rtl/unsigned_divider_if.sv | 23 ++
 rtl/unsigned_divider.sv | 127 ++++++++++++
 tb/tb_unsigned_divider.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/unsigned_divider_if.sv
// Operand/result bundle for the 16-by-8 unsigned divider.
// The master drives the operands and start, and the slave returns the results.
interface unsigned_divider_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/unsigned_divider.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero and quotient overflow are resolved on the accepting edge without iterating.
module unsigned_divider (
    input logic               clk,
    input logic               rst_n,
    unsigned_divider_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] part_q, part_d;
    logic [7:0] low_q, low_d;
    logic [7:0] dvs_q, dvs_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       dbz_q, dbz_d;
    logic       ovf_q, ovf_d;

    logic [8:0] trial;
    logic       take;
    logic [7:0] next_part;

    // Partial remainder is always below the divisor, so the difference fits 8 bits.
    assign trial     = {part_q, low_q[7]};
    assign take      = (trial >= {1'b0, dvs_q});
    assign next_part = take ? (trial[7:0] - dvs_q) : trial[7:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        low_d   = low_q;
        dvs_d   = dvs_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.divisor == 8'h00) begin
                        quo_d  = 8'hFF;
                        rem_d  = bus.dividend[7:0];
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (bus.dividend[15:8] >= bus.divisor) begin
                        quo_d  = 8'hFF;
                        rem_d  = 8'h00;
                        ovf_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        part_d  = bus.dividend[15:8];
                        low_d   = bus.dividend[7:0];
                        dvs_d   = bus.divisor;
                        acc_d   = 8'h00;
                        cnt_d   = 3'd0;
                        busy_d  = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                part_d = next_part;
                low_d  = {low_q[6:0], 1'b0};
                acc_d  = {acc_q[6:0], take};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quo_d   = {acc_q[6:0], take};
                    rem_d   = next_part;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            part_q  <= 8'h00;
            low_q   <= 8'h00;
            dvs_q   <= 8'h00;
            acc_q   <= 8'h00;
            quo_q   <= 8'h00;
            rem_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            low_q   <= low_d;
            dvs_q   <= dvs_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed and randomized checks of unsigned_divider against an arithmetic reference model.
module tb_unsigned_divider;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    unsigned_divider_if bus ();

    unsigned_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One division from drive to done; the reference is plain / and % with the flag rules.
    task automatic divide(input logic [15:0] a, input logic [7:0] b, input bit drop,
                          input string tag);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         elat, cyc, bcnt;
        edz = 1'b0;
        eov = 1'b0;
        if (b == 0) begin
            eq = 8'hFF; er = a[7:0]; edz = 1'b1; elat = 0;
        end else if (int'(a) / int'(b) > 255) begin
            eq = 8'hFF; er = 8'h00; eov = 1'b1; elat = 0;
        end else begin
            eq = 8'(int'(a) / int'(b));
            er = 8'(int'(a) % int'(b));
            elat = 8;
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc  = 0;
        bcnt = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, elat);
        check({tag, " busy_cycles"}, bcnt, elat);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " flags"}, {bus.div_by_zero, bus.overflow}, {edz, eov});
        check({tag, " busy_at_done"}, bus.busy, 0);
        if (drop) begin
            @(posedge clk);
            #1;
            check({tag, " done_drop"}, bus.done, 0);
            check({tag, " hold"}, {bus.quotient, bus.remainder}, {eq, er});
        end
    endtask

    initial begin
        int cyc, seen;
        logic [7:0] ra, rb, rr;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 16'h0;
        bus.divisor  = 8'h0;

        // Reset and idle behaviour
        #12;
        check("in_reset", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                           bus.overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        end
        check("idle_quiet", seen, 0);
        check("after_release", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);

        // Directed divides and flags
        divide(16'h1234, 8'h56, 1'b1, "norm_1234_56");
        divide(16'hFE01, 8'hFF, 1'b1, "norm_FE01_FF");
        divide(16'h00AB, 8'h00, 1'b1, "dbz_00AB");
        divide(16'h0500, 8'h05, 1'b1, "ovf_0500_05");

        // Start during RUN and operand changes are ignored
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h0064;
        bus.divisor  = 8'h07;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start    = 1'b1;
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'h03;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 3;
        while (bus.done !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("restart_latency", cyc, 8);
        check("restart_result", {bus.quotient, bus.remainder}, {8'h0E, 8'h02});
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("no_second_op", seen, 0);

        // Back-to-back: second start lands in the done cycle
        divide(16'h1234, 8'h56, 1'b0, "b2b_first");
        divide(16'hFE01, 8'hFF, 1'b1, "b2b_second");

        // Abort mid-RUN
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor  = 8'h56;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_clear", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero,
                              bus.overflow}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        divide(16'h1234, 8'h56, 1'b1, "post_abort");

        // Random exact-quotient cases, back-to-back
        for (int i = 0; i < 4000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            rr = 8'($urandom_range(0, int'(rb) - 1));
            divide(16'(int'(ra) * int'(rb) + int'(rr)), rb, 1'b0, "rand_norm");
            check("rand_q_is_a", bus.quotient, ra);
            check("rand_r_is_r", bus.remainder, rr);
        end

        // Random flag cases
        for (int i = 0; i < 300; i++) begin
            divide(16'($urandom_range(0, 65535)), 8'h00, 1'b0, "rand_dbz");
            rb = 8'($urandom_range(1, 255));
            ra = 8'($urandom_range(int'(rb), 255));
            divide({ra, 8'($urandom_range(0, 255))}, rb, 1'b0, "rand_ovf");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
